arm_trace_streamer: RTL and testbench



---
 rtl/arm_trace_streamer_if.sv | 11 +
 rtl/arm_trace_streamer.sv | 152 +++++++++++++++
 tb/tb_arm_trace_streamer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_trace_streamer_if.sv
// Valid/ready word stream carrying serialized trace records.
// tlast marks the final word of each record.
interface arm_trace_streamer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/arm_trace_streamer.sv
// Captures the core's per-cycle execution record into a record FIFO and streams it out as 32-bit words.
// Define ARM_TRACE_MEMDATA_EN to append a fifth word carrying store/load data.
module arm_trace_streamer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trace_en,
  input  logic [31:0]             PC_in,
  input  logic [31:0]             Instr_in,
  input  logic [31:0]             ALUResult_in,
  input  logic [31:0]             WriteData_in,
  input  logic [31:0]             ReadData_in,
  input  logic                    N_in,
  input  logic                    Z_in,
  input  logic                    C_in,
  input  logic                    V_in,
  input  logic                    PCSrc_in,
  input  logic                    MemWrite_in,
  input  logic                    RegWrite_in,
  arm_trace_streamer_if.master    tx,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [7:0]              drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef ARM_TRACE_MEMDATA_EN
  localparam int L = 5;
`else
  localparam int L = 4;
`endif
  localparam int         REC_W    = 32 * L;
  localparam logic [2:0] LAST_IDX = 3'(L - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cycle_cnt;
  logic             ovf;
  logic [6:0]       drop_local;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level, level_nxt;
  logic             push, pop, drop;
  logic [31:0]      header;
  logic [REC_W-1:0] rec_in, head_rec;
  logic [REC_W-1:0] mem [DEPTH];

  // Word 0 sits in the low 32 bits so word i is simply rec[32*i +: 32].
  assign header = {16'(cycle_cnt), ovf, drop_local, N_in, Z_in, C_in, V_in,
                   PCSrc_in, MemWrite_in, RegWrite_in, 1'b0};

`ifdef ARM_TRACE_MEMDATA_EN
  assign rec_in = {(MemWrite_in ? WriteData_in : ReadData_in),
                   ALUResult_in, Instr_in, PC_in, header};
`else
  logic unused_mem;
  assign unused_mem = ^{WriteData_in, ReadData_in};
  assign rec_in     = {ALUResult_in, Instr_in, PC_in, header};
`endif

  // A full FIFO still accepts when its head record finishes on the same edge.
  assign pop       = (state == S_SEND) && tx.tready && (idx == LAST_IDX);
  assign push      = trace_en && ((level < LW'(DEPTH)) || pop);
  assign drop      = trace_en && !push;
  assign level_nxt = level + LW'(push) - LW'(pop);

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (level != '0) begin
          state_nxt = S_SEND;
          idx_nxt   = '0;
        end
      end
      S_SEND: begin
        if (tx.tready) begin
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (level_nxt == '0) state_nxt = S_IDLE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
    end
  end

  // Overflow bookkeeping is handed to the next accepted record, then cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf        <= 1'b0;
      drop_local <= '0;
      drop_count <= '0;
    end else if (push) begin
      ovf        <= 1'b0;
      drop_local <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_local != 7'h7F) drop_local <= drop_local + 7'd1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // NOTE: record storage is not reset; the pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  assign head_rec   = mem[rd_ptr];
  assign tx.tvalid  = (state == S_SEND);
  assign tx.tlast   = (state == S_SEND) && (idx == LAST_IDX);
  assign tx.tdata   = (state == S_SEND) ? head_rec[32*idx +: 32] : '0;
  assign fifo_level = level;

endmodule

// File: tb/tb_arm_trace_streamer.sv
// Randomized and directed bench for arm_trace_streamer against a queue-based record model.
// Honours ARM_TRACE_MEMDATA_EN to expect five-word records.
module tb_arm_trace_streamer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
`ifdef ARM_TRACE_MEMDATA_EN
  localparam int L = 5;
`else
  localparam int L = 4;
`endif

  typedef logic [31:0] rec_t [5];

  logic        clk;
  logic        reset;
  logic        trace_en;
  logic [31:0] pc, instr, alu, wdata, rdata;
  logic        n, z, c, v, pcsrc, memw, regw;
  logic [3:0]  fifo_level;
  logic [7:0]  drop_count;

  arm_trace_streamer_if bus();

  arm_trace_streamer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .trace_en     (trace_en),
    .PC_in        (pc),
    .Instr_in     (instr),
    .ALUResult_in (alu),
    .WriteData_in (wdata),
    .ReadData_in  (rdata),
    .N_in         (n),
    .Z_in         (z),
    .C_in         (c),
    .V_in         (v),
    .PCSrc_in     (pcsrc),
    .MemWrite_in  (memw),
    .RegWrite_in  (regw),
    .tx           (bus),
    .fifo_level   (fifo_level),
    .drop_count   (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of whole records plus the word currently offered.
  rec_t        m_q[$];
  int          m_beat;
  bit          m_active;
  int unsigned m_cnt;
  int          m_drops;
  int          m_local;
  bit          m_ovf;
  logic [31:0] obs_data[$];
  logic        obs_last[$];

  task automatic model_reset();
    m_q.delete();
    m_beat   = 0;
    m_active = 0;
    m_cnt    = 0;
    m_drops  = 0;
    m_local  = 0;
    m_ovf    = 0;
  endtask

  task automatic model_edge();
    bit   fire, last, room, had;
    rec_t r;
    fire = m_active && bus.tready;
    last = fire && (m_beat == L - 1);
    had  = m_q.size() > 0;
    room = (m_q.size() < DEPTH) || last;
    if (trace_en) begin
      if (room) begin
        r[0] = {16'(m_cnt % 65536), m_ovf, 7'(m_local), n, z, c, v, pcsrc, memw, regw, 1'b0};
        r[1] = pc;
        r[2] = instr;
        r[3] = alu;
        r[4] = memw ? wdata : rdata;
        m_q.push_back(r);
        m_ovf   = 0;
        m_local = 0;
      end else begin
        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        m_local = (m_local < 127) ? m_local + 1 : 127;
        m_ovf   = 1;
      end
    end
    if (fire) begin
      if (last) begin
        m_q.delete(0);
        m_beat = 0;
        if (m_q.size() == 0) m_active = 0;
      end else begin
        m_beat++;
      end
    end else if (!m_active && had) begin
      m_active = 1;
    end
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic check_outputs();
    logic [31:0] exp_data;
    exp_data = 32'h0;
    if (m_active) exp_data = m_q[0][m_beat];
    check("tvalid",     32'(bus.tvalid), 32'(m_active));
    check("tdata",      bus.tdata, exp_data);
    check("tlast",      32'(bus.tlast), 32'(m_active && (m_beat == L - 1)));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("drop_count", 32'(drop_count), 32'(m_drops));
  endtask

  task automatic step();
    logic        stall;
    logic [31:0] held;
    stall = bus.tvalid && !bus.tready;
    held  = bus.tdata;
    if (bus.tvalid && bus.tready) begin
      obs_data.push_back(bus.tdata);
      obs_last.push_back(bus.tlast);
    end
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    if (stall && bus.tvalid) check("stall_hold", bus.tdata, held);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    trace_en = 1'b0;
    #1;
    model_reset();
    check("rst_tvalid", 32'(bus.tvalid), 32'd0);
    check("rst_tdata",  bus.tdata, 32'd0);
    check("rst_tlast",  32'(bus.tlast), 32'd0);
    check("rst_level",  32'(fifo_level), 32'd0);
    check("rst_drops",  32'(drop_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_fields();
    pc    = $urandom;
    instr = $urandom;
    alu   = $urandom;
    wdata = $urandom;
    rdata = $urandom;
    {n, z, c, v, pcsrc, memw, regw} = 7'($urandom);
  endtask

  task automatic drain();
    trace_en   = 1'b0;
    bus.tready = 1'b1;
    for (int i = 0; i < 400 && (m_q.size() > 0 || m_active); i++) step();
    step();
  endtask

  function automatic logic [31:0] obs_at(input int idx);
    if (idx < obs_data.size()) return obs_data[idx];
    return 'x;
  endfunction

  initial begin
    int          base;
    logic [31:0] hdr;
    rec_t        exp_rec;

    reset = 1'b1; trace_en = 1'b0; bus.tready = 1'b0;
    pc = '0; instr = '0; alu = '0; wdata = '0; rdata = '0;
    {n, z, c, v, pcsrc, memw, regw} = '0;
    do_reset();

    // Directed single record captured when the cycle counter reads 3.
    bus.tready = 1'b1;
    base = obs_data.size();
    while (m_cnt != 3) step();
    pc = 32'h0000_0008; instr = 32'hE281_0005; alu = 32'h0000_000A;
    wdata = '0; rdata = '0;
    {n, z, c, v, pcsrc, memw, regw} = 7'b0100_001;
    trace_en = 1'b1;
    step();
    trace_en = 1'b0;
    repeat (L + 4) step();
    check("t1_w0", obs_at(base + 0), 32'h0003_0042);
    check("t1_w1", obs_at(base + 1), 32'h0000_0008);
    check("t1_w2", obs_at(base + 2), 32'hE281_0005);
    check("t1_w3", obs_at(base + 3), 32'h0000_000A);
`ifdef ARM_TRACE_MEMDATA_EN
    check("t1_w4", obs_at(base + 4), 32'h0000_0000);
`endif
    for (int i = 0; i < L; i++) begin
      logic got_last;
      got_last = (base + i < obs_last.size()) ? obs_last[base + i] : 1'bx;
      check($sformatf("t1_tlast%0d", i), 32'(got_last), 32'(i == L - 1));
    end

    // Overflow: twelve captures into a stalled eight-deep FIFO.
    drain();
    base = obs_data.size();
    bus.tready = 1'b0;
    repeat (12) begin
      rand_fields();
      trace_en = 1'b1;
      step();
    end
    trace_en = 1'b0;
    check("ovf_level", 32'(fifo_level), 32'd8);
    check("ovf_drops", 32'(drop_count), 32'd4);
    // Capture on the very edge the head record completes while full.
    bus.tready = 1'b1;
    repeat (L - 1) step();
    rand_fields();
    trace_en = 1'b1;
    step();
    trace_en = 1'b0;
    check("full_pop_level", 32'(fifo_level), 32'd8);
    check("full_pop_drops", 32'(drop_count), 32'd4);
    drain();
    hdr = obs_at(base + 8 * L);
    check("ovf_hdr_flag",  32'(hdr[15]), 32'd1);
    check("ovf_hdr_drops", 32'(hdr[14:8]), 32'd4);
    check("ovf_records",   32'(obs_data.size() - base), 32'(9 * L));

    // Backpressure with tready toggling during a single record.
    base = obs_data.size();
    rand_fields();
    bus.tready = 1'b0;
    trace_en   = 1'b1;
    step();
    trace_en = 1'b0;
    exp_rec  = m_q[m_q.size() - 1];
    for (int i = 0; i < 4 * L + 4; i++) begin
      bus.tready = (i % 2 == 0);
      step();
    end
    check("bp_beats", 32'(obs_data.size() - base), 32'(L));
    for (int i = 0; i < L; i++) check($sformatf("bp_w%0d", i), obs_at(base + i), exp_rec[i]);

    // Reset while word 2 of the first of three queued records is on the bus.
    bus.tready = 1'b0;
    repeat (3) begin
      rand_fields();
      trace_en = 1'b1;
      step();
    end
    trace_en   = 1'b0;
    bus.tready = 1'b1;
    for (int i = 0; i < 20 && !(m_active && m_beat == 2); i++) step();
    check("pre_rst_level", 32'(fifo_level), 32'd3);
    do_reset();
    base = obs_data.size();
    rand_fields();
    trace_en = 1'b1;
    step();
    drain();
    hdr = obs_at(base);
    check("post_rst_cnt", 32'(hdr[31:16]), 32'd0);

    // Randomized traffic with varying sink pressure.
    for (int i = 0; i < 600; i++) begin
      rand_fields();
      trace_en   = ($urandom_range(0, 2) != 0);
      bus.tready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Counter wrap: capture after 70000 idle cycles.
    do_reset();
    bus.tready = 1'b1;
    repeat (70000) step();
    base = obs_data.size();
    rand_fields();
    trace_en = 1'b1;
    step();
    drain();
    hdr = obs_at(base);
    check("wrap_cnt", 32'(hdr[31:16]), 32'h0000_1170);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
